// File: rtl/demux4_pkg.sv
// Shared types and helpers for the 1:4 packet demux scheduler.
// Holds the channel count, state encoding and the round-robin search.
package demux4_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First enabled channel strictly after ptr, wrapping back to ptr itself last.
    function automatic logic [SELW-1:0] next_rr(input logic [SELW-1:0] ptr,
                                                input logic [NCH-1:0]  en);
        logic [SELW-1:0] c;
        next_rr = ptr;
        for (int i = NCH; i >= 1; i--) begin
            c = ptr + SELW'(i);
            if (en[c]) begin
                next_rr = c;
            end
        end
    endfunction

endpackage

// File: rtl/demux4_chreg.sv
// One-entry output register for a single demux channel; load-to-valid is 1 cycle.
// Reloads in the same cycle it drains, so the channel sustains one beat per cycle.
module demux4_chreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         rdy_i,
    input  logic [W-1:0] dat_i,
    input  logic         last_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o,
    output logic         last_o
);

    logic         vld_q,  vld_d;
    logic [W-1:0] dat_q,  dat_d;
    logic         last_q, last_d;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        last_d = last_q;
        if (load_i) begin
            vld_d  = 1'b1;
            dat_d  = dat_i;
            last_d = last_i;
        end else if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            last_q <= last_d;
        end
    end

    assign vld_o  = vld_q;
    assign dat_o  = dat_q;
    assign last_o = last_q;

endmodule

// File: rtl/demux4_sched.sv
// Packet steering for a 1:4 demux: addressed or round-robin destination, locked per packet.
// 1-cycle latency to out_valid; in_ready follows only the current target channel.
module demux4_sched
    import demux4_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [3:0]     cfg_en,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [1:0]     in_sel,
    input  logic           in_last,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready,
    output logic [4*W-1:0] out_data,
    output logic [3:0]     out_last,
    output logic [7:0]     drop_cnt,
    output logic           busy
);

    state_t          state_q, state_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic            lock_drop_q, lock_drop_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic [SELW-1:0] tgt;
    logic            drop;
    logic            accept;
    logic [NCH-1:0]  load;

    always_comb begin
        tgt  = lock_ch_q;
        drop = lock_drop_q;
        if (state_q == IDLE) begin
            tgt  = mode ? next_rr(rr_ptr_q, cfg_en) : in_sel;
            drop = mode ? (cfg_en == '0) : !cfg_en[in_sel];
        end
        // Only out_ready[tgt] is muxed in, so idle channels never gate the input.
        in_ready = drop || !out_valid[tgt] || out_ready[tgt];
        accept   = in_valid && in_ready;
        for (int k = 0; k < NCH; k++) begin
            load[k] = accept && !drop && (tgt == SELW'(k));
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_ch_d   = lock_ch_q;
        lock_drop_d = lock_drop_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept) begin
            if (state_q == IDLE) begin
                if (!in_last) begin
                    state_d     = BUSY;
                    lock_ch_d   = tgt;
                    lock_drop_d = drop;
                end
                if (mode && !drop) begin
                    rr_ptr_d = tgt;
                end
                if (drop && drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end else if (in_last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= SELW'(NCH - 1);
            lock_ch_q   <= '0;
            lock_drop_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_ch_q   <= lock_ch_d;
            lock_drop_q <= lock_drop_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        demux4_chreg #(.W(W)) u_chreg (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load[k]),
            .rdy_i  (out_ready[k]),
            .dat_i  (in_data),
            .last_i (in_last),
            .vld_o  (out_valid[k]),
            .dat_o  (out_data[k*W +: W]),
            .last_o (out_last[k])
        );
    end

    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q == BUSY);

endmodule

// File: doc/demux4_sched.md
Name: demux4_sched

Overview:
- Packet-level steering controller for the 1:4 demux datapath.
- Accepts a single valid/ready input stream and routes each packet to one of four output channels.
- Destination per packet comes from the input select (addressed mode) or from a round-robin pointer over enabled channels (round-robin mode).
- Each output channel has a one-entry output register, so every channel has independent backpressure.

Parameters:
- W, 8, data width of one beat.
- NCH, 4, number of output channels; fixed at 4, with a 2-bit select.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- mode  input  1  0 = addressed (use in_sel), 1 = round-robin; sampled at the first beat of a packet.
- cfg_en  input  4  per-channel enable mask.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  W  input beat payload.
- in_sel  input  2  destination channel; used on the first beat only, in addressed mode.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  4  per-channel beat valid.
- out_ready  input  4  per-channel sink ready.
- out_data  output  4*W  channel k occupies bits [k*W +: W].
- out_last  output  4  per-channel last flag.
- drop_cnt  output  8  saturating count of dropped packets.
- busy  output  1  high while a packet is open (state BUSY).

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, drop_cnt=0, busy=0, state=IDLE, rr_ptr=3 (so the first round-robin grant goes to ch0), lock_ch=0, lock_drop=0.
- FSM states: IDLE (no packet open) and BUSY (packet open, destination locked).
- Target channel t:
  - In IDLE, t = in_sel when mode=0.
  - In IDLE, t = the first enabled channel after rr_ptr (cyclic) when mode=1.
  - In BUSY, t = lock_ch.
- Drop decision, in IDLE: drop = (mode=0 && !cfg_en[in_sel]) || (mode=1 && cfg_en==0).
- in_ready (combinational):
  - Equals 1 when dropping.
  - Otherwise equals !out_valid[t] || out_ready[t].
  - Gives full throughput: a channel register loads in the same cycle it drains.
- Accept, non-drop:
  - out_data[t] <= in_data, out_last[t] <= in_last, out_valid[t] <= 1 on the next edge.
  - Latency is 1 cycle from input handshake to out_valid.
- Drain: when out_valid[k] && out_ready[k] and no load occurs on k that cycle, out_valid[k] <= 0. out_data/out_last hold their values.
- IDLE, first-beat accept:
  - If in_last=0: go to BUSY; lock_ch <= t; lock_drop <= drop.
  - If in_last=1 (single-beat packet): stay in IDLE.
  - In round-robin mode, rr_ptr <= t on every non-dropped packet start.
  - In addressed mode, rr_ptr is unchanged.
- BUSY:
  - mode, in_sel and cfg_en are ignored.
  - Beats go to lock_ch, or are discarded if lock_drop=1.
  - Accepting a beat with in_last=1 returns the FSM to IDLE.
- Dropped packet:
  - Every beat is accepted (in_ready=1) and discarded; no out_valid asserts.
  - drop_cnt increments by 1 at the packet's first beat and saturates at 255.
- Enable cleared mid-packet: the packet still completes to lock_ch. The new mask applies at the next packet start.
- Mode changed mid-packet: no effect until the next packet start.
- Channels drain independently; a stalled channel blocks input only while it is the current target.
- Reset asserted mid-packet: all state clears immediately. Any partial packet is lost and is not counted in drop_cnt.
- No combinational path from out_ready[j] to in_ready when j != t.

Decomposition:
- Package demux4_pkg:
  - NCH=4 and SELW=2.
  - State enum {IDLE, BUSY}.
  - Function next_rr(ptr, en) returning the first enabled channel after ptr, cyclically.
- Sub-module demux4_chreg: one-entry output register with load, drain and valid logic, plus data/last storage. Instantiated 4 times.

Test Plan:
- Reset then addressed mode, cfg_en=4'hF, single-beat packets with in_sel=0,1,2,3 and data 0xA0..0xA3, all out_ready=1 -> each out_valid[k] pulses 1 cycle after its handshake with out_data[k]=0xA0+k; in_ready stays 1.
- Round-robin mode, cfg_en=4'b1011, six 2-beat packets -> channel order 0,1,3,0,1,3; busy high between first and last beat; no beat reaches ch2.
- Addressed mode, in_sel=2, cfg_en[2]=0, 3-beat packet -> in_ready=1 for all 3 beats, out_valid stays 0, drop_cnt 0 -> 1. Then 300 dropped packets -> drop_cnt=255.
- Backpressure: out_ready[1]=0 while two beats target ch1 -> first beat accepted, in_ready=0 for the second. Raising out_ready[1] -> second beat accepted the same cycle, with no lost or duplicated beat.
- Mid-packet change: a 4-beat packet locked to ch3 in addressed mode; toggle mode, in_sel and cfg_en[3]=0 at beat 2 -> all 4 beats appear on ch3 with out_last only on beat 4.
- rst_n low for 1 cycle during beat 2 of a packet -> out_valid=0, busy=0, drop_cnt=0 asynchronously; the next packet routes correctly from IDLE with the round-robin grant at ch0.
